nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
- Multi-cycle wide adder that sequences one shared 4-bit ripple-carry slice over WIDTH-bit operands, one nibble per cycle, LSB nibble first.
- The carry is registered between nibbles.
- Uses a valid/ready start handshake and a valid/ready result handshake.
- Sits between a requesting datapath and the team's gate-level 4-bit adder, trading latency for area.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NNIB, WIDTH/4, derived localparam: number of nibble steps.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start_valid  in  1  requester presents operands.
- start_ready  out  1  controller can accept operands.
- a  in  WIDTH  operand A; sampled only on start handshake.
- b  in  WIDTH  operand B; sampled only on start handshake.
- cin  in  1  carry-in; sampled only on start handshake.
- result_valid  out  1  sum/cout hold a completed result.
- result_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
- cout  out  1  registered carry-out of the MSB nibble.
- busy  out  1  high in RUN or DONE.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst=1 at an edge): state=IDLE, nibble counter=0, carry_q=0, operand shift registers=0, sum=0, cout=0, result_valid=0. start_ready=1 from the first cycle after reset.
- rst takes priority over every other event.
- rst during RUN or DONE aborts the operation. No result is produced and the partial sum is discarded.
- Outputs are decoded from state:
  - start_ready = (state==IDLE)
  - result_valid = (state==DONE)
  - busy = (state!=IDLE)
- IDLE -> RUN on start_valid && start_ready:
  - latch a, b into shift registers; carry_q <= cin; cnt <= 0.
- RUN, each cycle:
  - slice inputs are a_sh[3:0], b_sh[3:0], carry_q.
  - slice sum nibble is shifted into the top of the sum accumulator (accumulator shifts right by 4).
  - carry_q <= slice cout.
  - a_sh and b_sh shift right by 4.
  - cnt++.
- RUN -> DONE after the step with cnt==NNIB-1:
  - on that same edge, the sum output register <= final accumulator and cout <= slice cout.
- DONE: sum and cout are held stable while result_ready=0.
- DONE -> IDLE on result_ready. sum and cout keep their last value; they are only meaningful while result_valid=1.
- Latency: handshake accepted at edge E0 gives result_valid=1 after edge E0+NNIB (4 cycles for WIDTH=16).
- Minimum initiation interval: NNIB+2 cycles. No back-to-back accept in DONE; start_ready only in IDLE.
- start_valid, a, b and cin are ignored outside IDLE. A request is never lost; the requester holds start_valid until start_ready.
- result_ready outside DONE has no effect.
- Width rules:
  - accumulator is exactly WIDTH bits.
  - carry out of the top nibble goes only to cout.
  - no signed overflow flag.
- Counter width is clog2(NNIB), minimum 1 bit.

Decomposition:
- Shared package nibble_add_pkg holds:
  - NIB_W = 4
  - state typedef (IDLE, RUN, DONE)
  - helper function nnib(width) returning width/NIB_W.
- One sub-module, nibble_add_slice: a purely combinational 4-bit ripple-carry adder (sum[3:0], cout, a[3:0], b[3:0], cin) built from one-bit full-adder gates.
- The slice is instantiated once; it contains no state.

Test Plan:
1. Single add, WIDTH=16: a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0; result_valid rises exactly 4 cycles after the accepting edge; busy high throughout.
2. Full carry ripple across nibbles: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
3. Backpressure: hold result_ready=0 for 3 cycles in DONE while pulsing start_valid with a=0x1111 -> result_valid, sum and cout stay stable; start_ready=0; the new request is accepted only after result_ready=1 and a return to IDLE.
4. Reset mid-operation: assert rst at RUN step 2 -> next cycle IDLE, start_ready=1, result_valid=0, sum=0, cout=0. Then a=0xA5A5, b=0x5A5A, cin=0 -> sum=0xFFFF, cout=0.
5. Operand isolation: change a and b every cycle during RUN -> result equals the sum of the values sampled at the accepting edge.
6. WIDTH=4 instance: a=0xF, b=0xF, cin=1 -> sum=0xF, cout=1, latency 1 cycle. Then random regression against (a+b+cin) for WIDTH=4, 16 and 32.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, controller
// states and the nibble-count helper.
package nibble_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int nnib(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// Combinational 4-bit ripple-carry adder built from one-bit full adders.
// Holds no state; the controller reuses it once per nibble.
module nibble_add_slice
  import nibble_add_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder that walks one shared 4-bit slice across the operands,
// LSB nibble first, with the carry registered between nibbles.
module nibble_serial_adder_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NNIB  = nnib(WIDTH);
  localparam int CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NNIB - 1);

  if (WIDTH < NIB_W || (WIDTH % NIB_W) != 0) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  // Handshakes: a transfer happens on an edge where valid and ready are both
  // high; start_ready only in IDLE, result_valid only in DONE.
  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              carry_q;
  logic [WIDTH-1:0]  a_sh, b_sh, acc, acc_next;
  logic [NIB_W-1:0]  slice_sum;
  logic              slice_cout;
  logic              accept, last_step;

  nibble_add_slice u_slice (
    .a    (a_sh[NIB_W-1:0]),
    .b    (b_sh[NIB_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New nibble enters at the top so the LSB nibble ends up at the bottom.
  if (NNIB == 1) begin : g_acc_single
    assign acc_next = slice_sum;
  end else begin : g_acc_shift
    assign acc_next = {slice_sum, acc[WIDTH-1:NIB_W]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    accept       = 1'b0;
    last_step    = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        accept      = start_valid;
        if (start_valid) state_next = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        last_step = (cnt == LAST);
        if (last_step) state_next = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      carry_q <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      carry_q <= cin;
      cnt     <= '0;
    end else if (state == RUN) begin
      acc     <= acc_next;
      carry_q <= slice_cout;
      a_sh    <= a_sh >> NIB_W;
      b_sh    <= b_sh >> NIB_W;
      cnt     <= cnt + 1'b1;
      if (last_step) begin
        sum  <= acc_next;
        cout <= slice_cout;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for the nibble-serial adder at WIDTH=4, 16 and 32.
module tb_nibble_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sv4 = 0, ci4 = 0, rr4 = 0, sr4, rv4, co4, bz4;
  logic [3:0]  a4 = 0, b4 = 0, s4;
  logic        sv16 = 0, ci16 = 0, rr16 = 0, sr16, rv16, co16, bz16;
  logic [15:0] a16 = 0, b16 = 0, s16;
  logic        sv32 = 0, ci32 = 0, rr32 = 0, sr32, rv32, co32, bz32;
  logic [31:0] a32 = 0, b32 = 0, s32;

  int n_cmp  = 0;
  int n_fail = 0;

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4), .a(a4), .b(b4),
    .cin(ci4), .result_valid(rv4), .result_ready(rr4), .sum(s4), .cout(co4), .busy(bz4)
  );

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start_valid(sv16), .start_ready(sr16), .a(a16), .b(b16),
    .cin(ci16), .result_valid(rv16), .result_ready(rr16), .sum(s16), .cout(co16), .busy(bz16)
  );

  nibble_serial_adder_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start_valid(sv32), .start_ready(sr32), .a(a32), .b(b32),
    .cin(ci32), .result_valid(rv32), .result_ready(rr32), .sum(s32), .cout(co32), .busy(bz32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic sv, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic rr);
    case (w)
      4:       begin sv4 = sv;  a4 = a[3:0];   b4 = b[3:0];   ci4 = ci;  rr4 = rr;  end
      16:      begin sv16 = sv; a16 = a[15:0]; b16 = b[15:0]; ci16 = ci; rr16 = rr; end
      default: begin sv32 = sv; a32 = a;       b32 = b;       ci32 = ci; rr32 = rr; end
    endcase
  endtask

  function automatic logic [31:0] get_sum(input int w);
    return (w == 4) ? {28'b0, s4} : (w == 16) ? {16'b0, s16} : s32;
  endfunction
  function automatic logic get_co(input int w);
    return (w == 4) ? co4 : (w == 16) ? co16 : co32;
  endfunction
  function automatic logic get_rv(input int w);
    return (w == 4) ? rv4 : (w == 16) ? rv16 : rv32;
  endfunction
  function automatic logic get_sr(input int w);
    return (w == 4) ? sr4 : (w == 16) ? sr16 : sr32;
  endfunction
  function automatic logic get_bz(input int w);
    return (w == 4) ? bz4 : (w == 16) ? bz16 : bz32;
  endfunction

  // One full transaction: accept, wait (bounded) for the result, release it.
  task automatic run(input int w, input logic [31:0] a, input logic [31:0] b, input logic ci,
                     input logic [31:0] es, input logic ec, input int elat, input bit scr,
                     input string tag);
    int lat;
    drive(w, 1'b1, a, b, ci, 1'b0);
    @(posedge clk); #1;
    drive(w, 1'b0, a, b, ci, 1'b0);
    lat = 0;
    while (get_rv(w) !== 1'b1 && lat < 40) begin
      check({tag, "_busy"}, 64'(get_bz(w)), 64'd1);
      if (scr) drive(w, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_sum"}, 64'(get_sum(w)), 64'(es));
    check({tag, "_cout"}, 64'(get_co(w)), 64'(ec));
    drive(w, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(w, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check({tag, "_idle_ready"}, 64'(get_sr(w)), 64'd1);
    check({tag, "_idle_busy"}, 64'(get_bz(w)), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", 64'(sr16), 64'd1);
    check("rst_result_valid", 64'(rv16), 64'd0);
    check("rst_busy", 64'(bz16), 64'd0);
    check("rst_sum", 64'(s16), 64'd0);
    check("rst_cout", 64'(co16), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_start_ready", 64'(sr16), 64'd1);

    // Basic adds and full carry ripple
    run(16, 32'h00FF, 32'h0001, 1'b0, 32'h0100, 1'b0, 4, 1'b0, "add_00ff");
    run(16, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 4, 1'b0, "ripple_ffff");
    run(16, 32'h1234, 32'h4321, 1'b1, 32'h5556, 1'b0, 4, 1'b0, "add_1234");

    // Backpressure in DONE with a pending request
    drive(16, 1'b1, 32'h0001, 32'h0002, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("bp_enter_done", 64'(rv16), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(16, 1'b1, 32'h1111, 32'h1111, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(rv16), 64'd1);
      check("bp_hold_sum", 64'(s16), 64'h0003);
      check("bp_hold_cout", 64'(co16), 64'd0);
      check("bp_no_ready", 64'(sr16), 64'd0);
    end
    drive(16, 1'b1, 32'h1111, 32'h1111, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("bp_release_valid", 64'(rv16), 64'd0);
    check("bp_release_idle", 64'(sr16), 64'd1);
    check("bp_release_busy", 64'(bz16), 64'd0);
    drive(16, 1'b1, 32'h1111, 32'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("bp_accept_busy", 64'(bz16), 64'd1);
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("bp_second_valid", 64'(rv16), 64'd1);
    check("bp_second_sum", 64'(s16), 64'h2222);
    check("bp_second_cout", 64'(co16), 64'd0);
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset in the middle of RUN discards the operation
    drive(16, 1'b1, 32'h0FFF, 32'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy_before", 64'(bz16), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_start_ready", 64'(sr16), 64'd1);
    check("abort_result_valid", 64'(rv16), 64'd0);
    check("abort_sum", 64'(s16), 64'd0);
    check("abort_cout", 64'(co16), 64'd0);
    run(16, 32'hA5A5, 32'h5A5A, 1'b0, 32'hFFFF, 1'b0, 4, 1'b0, "after_abort");

    // Operands change every RUN cycle; only the accepted values count
    run(16, 32'h3C3C, 32'h1E1E, 1'b1, 32'h5A5B, 1'b0, 4, 1'b1, "isolation");

    // Smallest instance
    run(4, 32'hF, 32'hF, 1'b1, 32'hF, 1'b1, 1, 1'b0, "w4_all_ones");
    run(32, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 8, 1'b0, "w32_ripple");

    // Random regression against a + b + cin
    for (int k = 0; k < 3; k++) begin
      int          w;
      logic [31:0] m, ra, rb;
      logic        rc;
      logic [63:0] t;
      w = (k == 0) ? 4 : (k == 1) ? 16 : 32;
      m = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      for (int i = 0; i < 10; i++) begin
        ra = $urandom & m;
        rb = $urandom & m;
        rc = 1'($urandom_range(0, 1));
        t  = 64'(ra) + 64'(rb) + 64'(rc);
        run(w, ra, rb, rc, t[31:0] & m, t[w], w / 4, 1'b0, $sformatf("rand_w%0d_%0d", w, i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
